rv_iopmp_bram_arbiter: RTL

Shares the single-port IOPMP entry BRAM between two requesters. The configuration path (128-bit word ops from the regmap width converter) reads and writes entries; the checker's entry walker only reads them. The checker has priority, and a bounded-wait counter guarantees configuration progress. The block also emits a one-cycle entry-update notification so the checker can drop stale cached entries.

---
 rtl/rv_iopmp_bram_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rv_iopmp_bram_arbiter.sv
// Arbitrates the single-port IOPMP entry BRAM between the configuration port and the
// checker's entry walker, routes read responses back and flags written entries.
module rv_iopmp_bram_arbiter #(
    parameter int NUMBER_ENTRIES = 8,
    parameter int READ_LATENCY   = 1,
    parameter int MAX_WAIT       = 4,
    localparam int AW = (NUMBER_ENTRIES > 1) ? $clog2(NUMBER_ENTRIES) : 1,
    localparam int WW = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          cfg_req_i,
    input  logic          cfg_we_i,
    input  logic [AW-1:0] cfg_addr_i,
    input  logic [127:0]  cfg_wdata_i,
    input  logic [15:0]   cfg_be_i,
    output logic          cfg_gnt_o,
    output logic          cfg_rvalid_o,
    output logic [127:0]  cfg_rdata_o,

    input  logic          chk_req_i,
    input  logic [AW-1:0] chk_addr_i,
    output logic          chk_gnt_o,
    output logic          chk_rvalid_o,
    output logic [127:0]  chk_rdata_o,

    output logic          en_bram_o,
    output logic          we_bram_o,
    output logic [AW-1:0] addr_bram_o,
    output logic [127:0]  din_bram_o,
    output logic [15:0]   be_bram_o,
    input  logic [127:0]  dout_bram_i,

    output logic          entry_upd_o,
    output logic [AW-1:0] entry_upd_idx_o
);

    localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);

    logic [WW-1:0]           r_wait;
    logic [READ_LATENCY-1:0] r_rsp_vld;
    logic [READ_LATENCY-1:0] r_rsp_cfg;
    logic                    r_upd;
    logic [AW-1:0]           r_upd_idx;

    logic                    w_cfg_gnt;
    logic                    w_chk_gnt;
    logic                    w_any_gnt;
    logic                    w_cfg_wr;

    // Checker wins contention unless cfg has already lost MAX_WAIT cycles in a row.
    always_comb begin
        w_cfg_gnt = cfg_req_i & (~chk_req_i | (r_wait == W_MAX));
        w_chk_gnt = chk_req_i & ~w_cfg_gnt;
        w_any_gnt = w_cfg_gnt | w_chk_gnt;
        w_cfg_wr  = w_cfg_gnt & cfg_we_i;
    end

    assign cfg_gnt_o = w_cfg_gnt;
    assign chk_gnt_o = w_chk_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait <= '0;
        end else if (cfg_req_i && !w_cfg_gnt) begin
            if (r_wait != W_MAX) begin
                r_wait <= r_wait + 1'b1;
            end
        end else begin
            r_wait <= '0;
        end
    end

    always_comb begin
        en_bram_o   = w_any_gnt;
        we_bram_o   = w_cfg_wr;
        addr_bram_o = '0;
        din_bram_o  = '0;
        be_bram_o   = '0;
        if (w_cfg_gnt) begin
            addr_bram_o = cfg_addr_i;
            din_bram_o  = cfg_wdata_i;
            be_bram_o   = cfg_be_i;
        end else if (w_chk_gnt) begin
            addr_bram_o = chk_addr_i;
        end
    end

    // Owner tag travels alongside the BRAM read so each response returns to its requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_vld <= '0;
            r_rsp_cfg <= '0;
        end else begin
            r_rsp_vld[0] <= w_any_gnt;
            r_rsp_cfg[0] <= w_cfg_gnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rsp_vld[i] <= r_rsp_vld[i-1];
                r_rsp_cfg[i] <= r_rsp_cfg[i-1];
            end
        end
    end

    assign cfg_rvalid_o = r_rsp_vld[READ_LATENCY-1] &  r_rsp_cfg[READ_LATENCY-1];
    assign chk_rvalid_o = r_rsp_vld[READ_LATENCY-1] & ~r_rsp_cfg[READ_LATENCY-1];
    assign cfg_rdata_o  = dout_bram_i;
    assign chk_rdata_o  = dout_bram_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd     <= 1'b0;
            r_upd_idx <= '0;
        end else begin
            r_upd <= w_cfg_wr;
            if (w_cfg_wr) begin
                r_upd_idx <= cfg_addr_i;
            end
        end
    end

    assign entry_upd_o     = r_upd;
    assign entry_upd_idx_o = r_upd_idx;

endmodule
